// File: rtl/com_pkg.sv
`default_nettype none
// ============================================================================
// Module      : com_pkg
// Description : Shared widths, enums and channel-expansion helpers for the
//               centre-of-mass pixel path.
// Revision    : 1.0
// ============================================================================
package com_pkg;

    localparam int X_W   = 11;
    localparam int Y_W   = 10;
    localparam int CNT_W = 20;

    typedef enum logic [1:0] {
        CHAN_R   = 2'd0,
        CHAN_G   = 2'd1,
        CHAN_B   = 2'd2,
        CHAN_RSV = 2'd3
    } chan_e;

    typedef enum logic [1:0] {
        ST_WAIT_SOF = 2'd0,
        ST_SCAN     = 2'd1,
        ST_FLUSH    = 2'd2
    } state_e;

    // MSB replication keeps full-scale inputs at 8'hFF and zero at 8'h00.
    function automatic logic [7:0] expand5(input logic [4:0] v);
        return {v, v[4:2]};
    endfunction

    function automatic logic [7:0] expand6(input logic [5:0] v);
        return {v, v[5:4]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rgb565_chan_extract.sv
`default_nettype none
// ============================================================================
// Module      : rgb565_chan_extract
// Description : Selects one RGB565 channel and expands it to 8 bits.
// Revision    : 1.0
// ============================================================================
module rgb565_chan_extract
    import com_pkg::*;
(
    input  logic [15:0] pixel_i,
    input  logic [1:0]  chan_sel_i,
    output logic [7:0]  chan_o
);

    always_comb begin
        chan_o = expand5(pixel_i[15:11]);
        case (chan_e'(chan_sel_i))
            CHAN_G:  chan_o = expand6(pixel_i[10:5]);
            CHAN_B:  chan_o = expand5(pixel_i[4:0]);
            default: chan_o = expand5(pixel_i[15:11]);
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/com_pixel_source.sv
`default_nettype none
// ============================================================================
// Module      : com_pixel_source
// Description : Raster tracker and channel-window mask generator producing
//               (x, y, valid) and an end-of-frame tabulate pulse.
// Revision    : 1.0
// ============================================================================
module com_pixel_source
    import com_pkg::*;
#(
    parameter int H_ACTIVE = 1024,
    parameter int V_ACTIVE = 768
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [15:0]      pixel_in,
    input  logic             pixel_valid_in,
    input  logic             sof_in,
    input  logic [1:0]       chan_sel_in,
    input  logic [7:0]       lo_in,
    input  logic [7:0]       hi_in,
    output logic [X_W-1:0]   x_out,
    output logic [Y_W-1:0]   y_out,
    output logic             valid_out,
    output logic             tabulate_out,
    output logic [CNT_W-1:0] count_out
);

    localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);

    state_e              state_q;
    logic [X_W-1:0]      x_q;
    logic [Y_W-1:0]      y_q;
    logic [1:0]          chan_sel_q;
    logic [7:0]          lo_q;
    logic [7:0]          hi_q;
    logic [1:0]          tab_cnt_q;

    logic                s1_valid_q;
    logic [X_W-1:0]      s1_x_q;
    logic [Y_W-1:0]      s1_y_q;
    logic [7:0]          s1_chan_q;

    logic                valid_q;
    logic [X_W-1:0]      x_out_q;
    logic [Y_W-1:0]      y_out_q;
    logic                tab_q;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;

    logic                w_sof_acc;
    logic                w_accept;
    logic                w_last;
    logic                w_tab_fire;
    logic                w_mask;
    logic [X_W-1:0]      w_x_cur;
    logic [Y_W-1:0]      w_y_cur;
    logic [1:0]          w_chan_sel;
    logic [7:0]          w_chan;

    // A start-of-frame pixel is always (0,0) and uses the freshly presented thresholds.
    assign w_sof_acc  = pixel_valid_in & sof_in;
    assign w_accept   = pixel_valid_in & (sof_in | (state_q == ST_SCAN));
    assign w_x_cur    = sof_in ? '0 : x_q;
    assign w_y_cur    = sof_in ? '0 : y_q;
    assign w_last     = w_accept & (w_x_cur == X_LAST) & (w_y_cur == Y_LAST);
    assign w_chan_sel = w_sof_acc ? chan_sel_in : chan_sel_q;
    assign w_tab_fire = (tab_cnt_q == 2'd1);
    assign w_mask     = s1_valid_q & (s1_chan_q >= lo_q) & (s1_chan_q <= hi_q);

    rgb565_chan_extract u_extract (
        .pixel_i    (pixel_in),
        .chan_sel_i (w_chan_sel),
        .chan_o     (w_chan)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= ST_WAIT_SOF;
            x_q        <= '0;
            y_q        <= '0;
            chan_sel_q <= 2'd0;
            lo_q       <= '0;
            hi_q       <= '0;
            tab_cnt_q  <= 2'd0;
        end else begin
            if (w_sof_acc) begin
                chan_sel_q <= chan_sel_in;
                lo_q       <= lo_in;
                hi_q       <= hi_in;
            end
            if (w_accept) begin
                if (w_x_cur == X_LAST) begin
                    x_q <= '0;
                    y_q <= (w_y_cur == Y_LAST) ? '0 : w_y_cur + Y_W'(1);
                end else begin
                    x_q <= w_x_cur + X_W'(1);
                    y_q <= w_y_cur;
                end
            end
            // Tabulate tracks the drain independently so a new frame may start in FLUSH.
            if (w_last) begin
                tab_cnt_q <= 2'd2;
            end else if (tab_cnt_q != 2'd0) begin
                tab_cnt_q <= tab_cnt_q - 2'd1;
            end
            case (state_q)
                ST_WAIT_SOF: begin
                    if (w_sof_acc) state_q <= w_last ? ST_FLUSH : ST_SCAN;
                end
                ST_SCAN: begin
                    if (w_last) state_q <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (w_sof_acc)       state_q <= w_last ? ST_FLUSH : ST_SCAN;
                    else if (w_tab_fire) state_q <= ST_WAIT_SOF;
                end
                default: state_q <= ST_WAIT_SOF;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, w_mask};
        if (w_tab_fire) begin
            cnt_d = {{(CNT_W-1){1'b0}}, w_mask};
        end
        if (w_sof_acc && (state_q == ST_SCAN)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_chan_q  <= '0;
            valid_q    <= 1'b0;
            x_out_q    <= '0;
            y_out_q    <= '0;
            tab_q      <= 1'b0;
            count_q    <= '0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= w_accept;
            if (w_accept) begin
                s1_x_q    <= w_x_cur;
                s1_y_q    <= w_y_cur;
                s1_chan_q <= w_chan;
            end
            valid_q <= w_mask;
            if (w_mask) begin
                x_out_q <= s1_x_q;
                y_out_q <= s1_y_q;
            end
            tab_q <= w_tab_fire;
            if (w_tab_fire) begin
                count_q <= cnt_q;
            end
            cnt_q <= cnt_d;
        end
    end

    assign x_out        = x_out_q;
    assign y_out        = y_out_q;
    assign valid_out    = valid_q;
    assign tabulate_out = tab_q;
    assign count_out    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_com_pixel_source.sv
`default_nettype none
// ============================================================================
// Module      : tb_com_pixel_source
// Description : Directed self-checking bench for com_pixel_source (16x8 raster).
// Revision    : 1.0
// ============================================================================
module tb_com_pixel_source;

    localparam int H    = 16;
    localparam int V    = 8;
    localparam int NPIX = H * V;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [15:0] pixel_in;
    logic        pixel_valid_in;
    logic        sof_in;
    logic [1:0]  chan_sel_in;
    logic [7:0]  lo_in;
    logic [7:0]  hi_in;
    logic [10:0] x_out;
    logic [9:0]  y_out;
    logic        valid_out;
    logic        tabulate_out;
    logic [19:0] count_out;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int vx_q[$];
    int vy_q[$];
    int vc_q[$];
    int tc_q[$];
    int tn_q[$];

    com_pixel_source #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .pixel_in       (pixel_in),
        .pixel_valid_in (pixel_valid_in),
        .sof_in         (sof_in),
        .chan_sel_in    (chan_sel_in),
        .lo_in          (lo_in),
        .hi_in          (hi_in),
        .x_out          (x_out),
        .y_out          (y_out),
        .valid_out      (valid_out),
        .tabulate_out   (tabulate_out),
        .count_out      (count_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (valid_out) begin
            vx_q.push_back(int'(x_out));
            vy_q.push_back(int'(y_out));
            vc_q.push_back(cyc);
        end
        if (tabulate_out) begin
            tc_q.push_back(cyc);
            tn_q.push_back(int'(count_out));
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    function automatic logic [15:0] frame_pix(input int mode, input int x, input int y);
        case (mode)
            0:       return 16'hF800;
            1:       return (x == 10 && y == 5) ? 16'h07E0 : 16'hFFBF;
            2:       return 16'(x * 2731 + y * 977);
            3:       return {5'h1F, 6'h3F, 5'(x + 8)};
            default: return {5'(x + y), 11'h000};
        endcase
    endfunction

    task automatic drive(input logic v, input logic s, input logic [15:0] p);
        pixel_valid_in = v;
        sof_in         = s;
        pixel_in       = p;
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input int n);
        pixel_valid_in = 1'b0;
        sof_in         = 1'b0;
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic clear_q();
        vx_q.delete(); vy_q.delete(); vc_q.delete(); tc_q.delete(); tn_q.delete();
    endtask

    task automatic send_frame(input int mode, input bit gap, output int first_c, output int last_c);
        first_c = cyc;
        last_c  = cyc;
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                if (x == 0 && y == 0) first_c = cyc;
                last_c = cyc;
                drive(1'b1, (x == 0 && y == 0), frame_pix(mode, x, y));
                if (gap) drive(1'b0, 1'b0, 16'h0000);
            end
        end
        pixel_valid_in = 1'b0;
        sof_in         = 1'b0;
    endtask

    task automatic test_reset();
        tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b expected 0", valid_out); end
        tests++; if ({x_out, y_out} !== 21'd0) begin fails++; $display("FAIL reset_xy: got (%0d,%0d) expected (0,0)", x_out, y_out); end
        tests++; if (tabulate_out !== 1'b0) begin fails++; $display("FAIL reset_tab: got %0b expected 0", tabulate_out); end
        tests++; if (count_out !== 20'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", count_out); end
    endtask

    task automatic test_full_frame();
        int f, l, errs, n;
        clear_q();
        chan_sel_in = 2'd0; lo_in = 8'd200; hi_in = 8'd255;
        send_frame(0, 1'b0, f, l);
        idle(8);
        n = vx_q.size();
        tests++; if (n != NPIX) begin fails++; $display("FAIL full_count: got %0d expected %0d", n, NPIX); end
        errs = 0;
        for (int i = 0; i < n; i++) if (vx_q[i] != i % H || vy_q[i] != i / H || vc_q[i] != f + 2 + i) errs++;
        tests++; if (errs != 0) begin fails++; $display("FAIL full_order: got %0d bad beats expected 0", errs); end
        tests++; if (n == 0 || vx_q[n-1] != H-1 || vy_q[n-1] != V-1) begin
            fails++; $display("FAIL full_last: got (%0d,%0d) expected (%0d,%0d)", (n > 0) ? vx_q[n-1] : -1, (n > 0) ? vy_q[n-1] : -1, H-1, V-1);
        end
        tests++; if (tc_q.size() != 1 || tc_q[0] != l + 3) begin
            fails++; $display("FAIL full_tab: got %0d pulses first at %0d expected 1 at %0d", tc_q.size(), (tc_q.size() > 0) ? tc_q[0] : -1, l + 3);
        end
        tests++; if (count_out !== 20'(NPIX)) begin fails++; $display("FAIL full_cnt: got %0d expected %0d", count_out, NPIX); end
    endtask

    task automatic test_sparse();
        int f, l;
        clear_q();
        chan_sel_in = 2'd1; lo_in = 8'd250; hi_in = 8'd255;
        send_frame(1, 1'b0, f, l);
        idle(8);
        tests++; if (vx_q.size() != 1 || vx_q[0] != 10 || vy_q[0] != 5) begin
            fails++; $display("FAIL sparse_hit: got %0d beats first (%0d,%0d) expected 1 at (10,5)", vx_q.size(), (vx_q.size() > 0) ? vx_q[0] : -1, (vy_q.size() > 0) ? vy_q[0] : -1);
        end
        tests++; if (x_out !== 11'd10 || y_out !== 10'd5) begin fails++; $display("FAIL sparse_hold: got (%0d,%0d) expected (10,5)", x_out, y_out); end
        tests++; if (count_out !== 20'd1) begin fails++; $display("FAIL sparse_cnt: got %0d expected 1", count_out); end
    endtask

    task automatic test_inverted();
        int f, l;
        clear_q();
        chan_sel_in = 2'd0; lo_in = 8'd100; hi_in = 8'd50;
        send_frame(2, 1'b0, f, l);
        idle(8);
        tests++; if (vx_q.size() != 0) begin fails++; $display("FAIL inv_valid: got %0d beats expected 0", vx_q.size()); end
        tests++; if (tc_q.size() != 1) begin fails++; $display("FAIL inv_tab: got %0d pulses expected 1", tc_q.size()); end
        tests++; if (count_out !== 20'd0) begin fails++; $display("FAIL inv_cnt: got %0d expected 0", count_out); end
    endtask

    task automatic test_channels();
        int f, l, errs;
        clear_q();
        chan_sel_in = 2'd2; lo_in = 8'd132; hi_in = 8'd132;
        send_frame(3, 1'b0, f, l);
        idle(8);
        errs = 0;
        for (int i = 0; i < vx_q.size(); i++) if (vx_q[i] != 8 || vy_q[i] != i) errs++;
        tests++; if (vx_q.size() != V || errs != 0) begin fails++; $display("FAIL blue_mask: got %0d beats %0d bad expected %0d beats 0 bad", vx_q.size(), errs, V); end
        tests++; if (count_out !== 20'(V)) begin fails++; $display("FAIL blue_cnt: got %0d expected %0d", count_out, V); end
        clear_q();
        chan_sel_in = 2'd3; lo_in = 8'd41; hi_in = 8'd41;
        send_frame(4, 1'b0, f, l);
        idle(8);
        tests++; if (vx_q.size() != 6 || vx_q[0] != 5 || vy_q[0] != 0) begin
            fails++; $display("FAIL rsv_mask: got %0d beats first (%0d,%0d) expected 6 first (5,0)", vx_q.size(), (vx_q.size() > 0) ? vx_q[0] : -1, (vy_q.size() > 0) ? vy_q[0] : -1);
        end
        tests++; if (count_out !== 20'd6) begin fails++; $display("FAIL rsv_cnt: got %0d expected 6", count_out); end
    endtask

    task automatic test_abort();
        int f, l, n;
        clear_q();
        chan_sel_in = 2'd0; lo_in = 8'd200; hi_in = 8'd255;
        for (int i = 0; i < 3 * H + 10; i++) drive(1'b1, (i == 0), 16'hF800);
        send_frame(0, 1'b0, f, l);
        idle(8);
        n = vx_q.size();
        tests++; if (n != 3 * H + 10 + NPIX) begin fails++; $display("FAIL abort_count: got %0d expected %0d", n, 3 * H + 10 + NPIX); end
        tests++; if (n < 3 * H + 11 || vx_q[3*H+9] != 9 || vy_q[3*H+9] != 3 || vx_q[3*H+10] != 0 || vy_q[3*H+10] != 0) begin
            fails++; $display("FAIL abort_restart: got %0d beats, coords around restart wrong, expected (9,3) then (0,0)", n);
        end
        tests++; if (tc_q.size() != 1 || tc_q[0] != l + 3) begin
            fails++; $display("FAIL abort_tab: got %0d pulses first at %0d expected 1 at %0d", tc_q.size(), (tc_q.size() > 0) ? tc_q[0] : -1, l + 3);
        end
        tests++; if (count_out !== 20'(NPIX)) begin fails++; $display("FAIL abort_cnt: got %0d expected %0d", count_out, NPIX); end
    endtask

    task automatic test_gapped();
        int f, l, errs, n;
        clear_q();
        chan_sel_in = 2'd0; lo_in = 8'd200; hi_in = 8'd255;
        send_frame(0, 1'b1, f, l);
        idle(8);
        n = vx_q.size();
        errs = 0;
        for (int i = 0; i < n; i++) if (vx_q[i] != i % H || vy_q[i] != i / H || vc_q[i] != f + 2 + 2 * i) errs++;
        tests++; if (n != NPIX || errs != 0) begin fails++; $display("FAIL gap_order: got %0d beats %0d bad expected %0d beats 0 bad", n, errs, NPIX); end
        tests++; if (tc_q.size() != 1 || tc_q[0] != l + 3) begin
            fails++; $display("FAIL gap_tab: got %0d pulses first at %0d expected 1 at %0d", tc_q.size(), (tc_q.size() > 0) ? tc_q[0] : -1, l + 3);
        end
    endtask

    task automatic test_back_to_back();
        int f0, l0, f1, l1;
        clear_q();
        chan_sel_in = 2'd0; lo_in = 8'd200; hi_in = 8'd255;
        send_frame(0, 1'b0, f0, l0);
        send_frame(0, 1'b0, f1, l1);
        idle(8);
        tests++; if (vx_q.size() != 2 * NPIX) begin fails++; $display("FAIL b2b_count: got %0d expected %0d", vx_q.size(), 2 * NPIX); end
        tests++; if (tc_q.size() != 2 || tc_q[0] != l0 + 3 || tc_q[1] != l1 + 3) begin
            fails++; $display("FAIL b2b_tab: got %0d pulses first at %0d expected 2 at %0d and %0d", tc_q.size(), (tc_q.size() > 0) ? tc_q[0] : -1, l0 + 3, l1 + 3);
        end
        tests++; if (tn_q.size() != 2 || tn_q[0] != NPIX || tn_q[1] != NPIX) begin
            fails++; $display("FAIL b2b_cnt: got %0d counts first %0d expected 2 of %0d", tn_q.size(), (tn_q.size() > 0) ? tn_q[0] : -1, NPIX);
        end
        tests++; if (vc_q.size() <= NPIX || tc_q.size() == 0 || vc_q[NPIX] != tc_q[0]) begin
            fails++; $display("FAIL b2b_overlap: got first new-frame beat at %0d expected %0d", (vc_q.size() > NPIX) ? vc_q[NPIX] : -1, l0 + 3);
        end
    endtask

    task automatic test_reset_mid();
        int f, l;
        chan_sel_in = 2'd0; lo_in = 8'd200; hi_in = 8'd255;
        for (int i = 0; i < 40; i++) drive(1'b1, (i == 0), 16'hF800);
        pixel_valid_in = 1'b0;
        sof_in         = 1'b0;
        #2;
        rst_n_in = 1'b0;
        #1;
        tests++; if (valid_out !== 1'b0 || x_out !== 11'd0 || y_out !== 10'd0) begin
            fails++; $display("FAIL rstmid_out: got valid %0b (%0d,%0d) expected 0 (0,0)", valid_out, x_out, y_out);
        end
        tests++; if (count_out !== 20'd0 || tabulate_out !== 1'b0) begin
            fails++; $display("FAIL rstmid_cnt: got count %0d tab %0b expected 0 0", count_out, tabulate_out);
        end
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        idle(2);
        clear_q();
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 16'hF800);
        idle(8);
        tests++; if (vx_q.size() != 0 || tc_q.size() != 0) begin
            fails++; $display("FAIL rstmid_ignore: got %0d beats %0d pulses expected 0 0", vx_q.size(), tc_q.size());
        end
        clear_q();
        send_frame(0, 1'b0, f, l);
        idle(8);
        tests++; if (vx_q.size() != NPIX || vx_q[0] != 0 || vy_q[0] != 0 || count_out !== 20'(NPIX)) begin
            fails++; $display("FAIL rstmid_resume: got %0d beats count %0d expected %0d beats count %0d", vx_q.size(), count_out, NPIX, NPIX);
        end
    endtask

    initial begin
        rst_n_in       = 1'b0;
        pixel_in       = 16'h0000;
        pixel_valid_in = 1'b0;
        sof_in         = 1'b0;
        chan_sel_in    = 2'd0;
        lo_in          = 8'd0;
        hi_in          = 8'd0;
        repeat (3) @(posedge clk_in);
        #1;
        test_reset();
        rst_n_in = 1'b1;
        idle(2);
        test_full_frame();
        test_sparse();
        test_inverted();
        test_channels();
        test_abort();
        test_gapped();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/com_pixel_source.md
# com_pixel_source

Raster-scanning mask generator that produces the thresholded pixel-coordinate stream consumed by `center_of_mass`. It takes the camera's RGB565 pixel stream, tracks raster position, and emits `(x, y, valid)` for every pixel whose selected colour channel lies inside a programmable window. It also emits a single `tabulate` pulse once per completed frame. It sits between the camera/frame-buffer read path and `center_of_mass`.

## Interface

Parameters:
- `H_ACTIVE`, 1024: pixels per row.
- `V_ACTIVE`, 768: rows per frame.

Ports:
- `clk_in`, input, 1: system clock.
- `rst_n_in`, input, 1: asynchronous, active-low reset.
- `pixel_in`, input, 16: RGB565 pixel.
- `pixel_valid_in`, input, 1: pixel strobe, one pixel per asserted cycle, in raster order.
- `sof_in`, input, 1: start of frame; qualified by `pixel_valid_in` and marks pixel (0,0).
- `chan_sel_in`, input, 2: selects the compared channel: 0 = R, 1 = G, 2 = B, 3 = reserved (treated as R).
- `lo_in`, input, 8: lower threshold, inclusive.
- `hi_in`, input, 8: upper threshold, inclusive.
- `x_out`, output, 11: masked pixel column.
- `y_out`, output, 10: masked pixel row.
- `valid_out`, output, 1: masked pixel strobe.
- `tabulate_out`, output, 1: one-cycle pulse at end of a completed frame.
- `count_out`, output, 20: masked-pixel count of the last completed frame.

## Operation

- FSM states: `WAIT_SOF`, `SCAN`, `FLUSH`.
- `WAIT_SOF` behaviour:
  - Pixels without `sof_in` are dropped.
  - `pixel_valid_in && sof_in` → `SCAN`. That pixel is processed as (0,0).
  - At the same edge, `chan_sel_in`, `lo_in` and `hi_in` are latched; they stay constant for the whole frame.
- `SCAN` behaviour:
  - Each valid pixel is processed at the current (x,y); then x increments.
  - When x = `H_ACTIVE`-1, x wraps to 0 and y increments.
  - The pixel at (`H_ACTIVE`-1, `V_ACTIVE`-1) → `FLUSH`.
- `SCAN` restart: `sof_in` on a valid pixel aborts the current frame.
  - Coordinates restart at (0,0) for that pixel and thresholds are re-latched.
  - The frame counter clears; no `tabulate_out` is issued for the aborted frame.
- `FLUSH` behaviour:
  - Waits for the pipeline to drain, then pulses `tabulate_out` → `WAIT_SOF`.
  - Valid pixels arriving in `FLUSH` are dropped unless `sof_in` is set. In that case the pixel starts a new frame in `SCAN`, and the pending tabulate still fires.
- Channel expansion to 8 bits uses MSB replication:
  - R5 → `{R,R[4:2]}`.
  - G6 → `{G,G[5:4]}`.
  - B5 → `{B,B[4:2]}`.
- Mask rule: `lo <= chan <= hi`, unsigned. If `lo > hi`, no pixel is ever masked.
- Masked-pixel counter: 20-bit, increments per masked pixel. At `tabulate_out` it is copied to `count_out` and cleared.
  - A masked pixel in the same cycle as the copy counts toward the new frame.

## Timing

- Reset values (asynchronous reset, all outputs 0): `x_out`, `y_out`, `valid_out`, `tabulate_out` and `count_out` all 0. The FSM resets to `WAIT_SOF` and the counters to 0.
- Pipeline, 2 stages:
  - Stage 1 registers the coordinates, the expanded channel and the valid flag.
  - Stage 2 registers the compare result and drives the outputs.
- Latency: `valid_out` asserts 2 cycles after the accepted `pixel_valid_in`.
- `x_out` and `y_out` hold their last value when `valid_out` = 0.
- `tabulate_out` is asserted exactly 3 cycles after the last pixel is accepted, i.e. the cycle after that pixel's `valid_out` slot. It is never coincident with `valid_out` of the same frame.
- A new frame's first `valid_out` may coincide with `tabulate_out` of the previous frame.
- Gaps in `pixel_valid_in` stall nothing; there is no backpressure. Coordinates advance only on valid cycles.
- Reset mid-frame: the pipeline contents are discarded and no `tabulate_out` is issued.

## Structure

- Shared package `com_pkg` holds:
  - Coordinate widths: X_W = 11, Y_W = 10.
  - Count width: CNT_W = 20.
  - The channel-select enum `chan_e`.
  - The FSM state enum.
- Sub-module `rgb565_chan_extract`: combinational selection of one expanded channel from `pixel_in` and `chan_sel`. Instantiated once in stage 1.

## Test plan

- **Full frame, all masked.** Stimulus: 1024×768 frame with `sof_in` on the first pixel, R = 31, R window [200,255]. Required response:
  - 786432 `valid_out` pulses in raster order, ending at (1023,767).
  - One `tabulate_out` 3 cycles after the last input; `count_out` = 786432.
- **Sparse mask.** Stimulus: single frame with only pixel (10,5) having G = 63, window G [250,255]. Required response: exactly one `valid_out` with x = 10, y = 5; `count_out` = 1.
- **Inverted window.** Stimulus: `lo_in` = 100, `hi_in` = 50 over a full frame. Required response: no `valid_out`; `tabulate_out` fires; `count_out` = 0.
- **Aborted frame.** Stimulus: `sof_in` re-asserted at pixel 500 of row 3. Required response: coordinates restart at (0,0); no `tabulate_out` until the restarted frame completes.
- **Gapped input.** Stimulus: `pixel_valid_in` toggling 1/0 for a whole frame. Required response: identical coordinate sequence as contiguous input, with `valid_out` also gapped.
- **Reset mid-frame.** Stimulus: assert `rst_n_in` low mid-frame, then release. Required response:
  - All outputs 0 immediately, without waiting for a clock edge.
  - Pixels without `sof_in` are ignored until the next `sof_in`.
